harmonic_select: RTL and testbench
==================================

HARMONIC_SELECT -- requirements
Module: harmonic_select

Interface
REQ-001 The block SHALL have the following parameter: WORD_SIZE, 16, width of each signed two's-complement re/im component.
REQ-002 The block SHALL have the following parameter: N_BINS, 16, number of FFT bins per frame; power of two, 4..64.
REQ-003 The block SHALL have the following parameter: SEL_W, $clog2(N_BINS), bin index width (derived; not overridden).
REQ-004 The block SHALL have the following port: i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the following port: i_rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have the following port: i_frame_valid  input  1  a full FFT frame is present on i_bins_*.
REQ-007 The block SHALL have the following ports, where bin k occupies bits [k*WORD_SIZE +: WORD_SIZE]: i_bins_re and i_bins_im  input  N_BINS*WORD_SIZE  flattened frame.
REQ-008 The block SHALL have the following port: i_mode  input  1  0 = single-bin, 1 = scan; sampled at frame capture.
REQ-009 The block SHALL have the following port: i_select  input  SEL_W  bin index for single-bin mode, or first bin in scan mode; sampled at capture.
REQ-010 The block SHALL have the following port: i_scan_last  input  SEL_W  last bin in scan mode; sampled at capture.
REQ-011 The block SHALL have the following port: i_ready  input  1  downstream accepts the current output.
REQ-012 The block SHALL have the following ports: o_valid  output  1  output word valid; o_busy  output  1  frame being emitted.
REQ-013 The block SHALL have the following ports: o_harmonic_re and o_harmonic_im  output  WORD_SIZE each  selected bin; o_index  output  SEL_W  its index.

Function
REQ-014 The block SHALL implement the two-state FSM IDLE and EMIT, with o_busy = (state == EMIT).
REQ-015 In IDLE, when i_frame_valid=1 the block SHALL, on that edge, latch all N_BINS re/im words into an internal frame buffer together with i_mode, i_select and i_scan_last, and enter EMIT.
REQ-016 When i_frame_valid=1 in EMIT, the frame SHALL be ignored with no state change, including in the cycle of the final handshake.
REQ-017 On entry to EMIT, the outputs SHALL hold the bin at i_select with o_valid=1, registered and visible one cycle after the capture edge.
REQ-018 A handshake SHALL occur on any edge with o_valid=1 and i_ready=1; while o_valid=1 and i_ready=0, o_harmonic_*, o_index and o_valid SHALL remain stable.
REQ-019 In single-bin mode, the first handshake SHALL return the FSM to IDLE with o_valid=0.
REQ-020 In scan mode, each handshake SHALL advance the output to index (o_index+1) mod N_BINS; the handshake at index i_scan_last SHALL return the FSM to IDLE.
REQ-021 Scan wrap-around: for first > last, the block SHALL emit first..N_BINS-1 then 0..last; for first == last, it SHALL emit exactly one bin; the bin count SHALL be ((last-first) mod N_BINS)+1.
REQ-022 The frame buffer SHALL be written only on a capture; later changes on i_bins_* SHALL NOT alter emitted data.
REQ-023 Sustained throughput SHALL be one bin per cycle while i_ready=1; a new frame SHALL be accepted no earlier than the cycle after the return to IDLE.

Reset
REQ-024 Asserting i_rst SHALL immediately force state=IDLE, o_valid=0, o_busy=0, o_harmonic_re=0, o_harmonic_im=0 and o_index=0, including mid-scan, with no pending handshake completed.
REQ-025 The frame buffer need not be reset; its contents SHALL be unobservable until the next capture.
REQ-026 On i_rst deassertion the block SHALL accept a frame on the first clock edge.

Configuration
REQ-027 With macro HARMONIC_SELECT_MAGNITUDE_EN defined, the block SHALL add the port o_magnitude  output  WORD_SIZE+1, equal to |re|+|im| of the emitted bin, unsigned, with the same timing and hold rules as o_harmonic_*, and reset to 0.
REQ-028 In the magnitude computation, |most-negative| SHALL yield 2^(WORD_SIZE-1) with no saturation.
REQ-029 Without HARMONIC_SELECT_MAGNITUDE_EN, the o_magnitude port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 The bench SHALL cover: single-bin, bin k holding re=k, im=-k, i_select=5, i_ready=1 -> one cycle with o_valid=1, re=5, im=-5, o_index=5, then IDLE.
REQ-031 The bench SHALL cover: scan first=14, last=1, i_ready=1 -> o_index 14,15,0,1 on consecutive cycles, then o_valid=0 and o_busy=0.
REQ-032 The bench SHALL cover: scan 2..4 with i_ready low for 3 cycles at index 3 -> index 3 held stable for 4 cycles and no index skipped.
REQ-033 The bench SHALL cover: i_frame_valid pulsed during EMIT with different data -> ignored; emitted values come from the first frame.
REQ-034 The bench SHALL cover: i_rst asserted mid-scan at index 7 -> all outputs 0 asynchronously, then a new frame accepted on the first edge after release.
REQ-035 The bench SHALL cover, with HARMONIC_SELECT_MAGNITUDE_EN defined: re=-32768, im=32767 -> o_magnitude=65535.

Source files
------------

// File: rtl/harmonic_select.sv
// harmonic_select: captures one FFT frame and emits a single bin or a wrapping bin range with valid/ready.
// Optional |re|+|im| output on o_magnitude when HARMONIC_SELECT_MAGNITUDE_EN is defined.
module harmonic_select #(
   parameter int WORD_SIZE = 16,
   parameter int N_BINS    = 16,
   parameter int SEL_W     = $clog2(N_BINS)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_frame_valid,
   input  logic [N_BINS*WORD_SIZE-1:0] i_bins_re,
   input  logic [N_BINS*WORD_SIZE-1:0] i_bins_im,
   input  logic                        i_mode,
   input  logic [SEL_W-1:0]            i_select,
   input  logic [SEL_W-1:0]            i_scan_last,
   input  logic                        i_ready,
   output logic                        o_valid,
   output logic                        o_busy,
   output logic [WORD_SIZE-1:0]        o_harmonic_re,
   output logic [WORD_SIZE-1:0]        o_harmonic_im,
   output logic [SEL_W-1:0]            o_index
`ifdef HARMONIC_SELECT_MAGNITUDE_EN
   ,output logic [WORD_SIZE:0]         o_magnitude
`endif
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t               state;
   logic [WORD_SIZE-1:0] frame_re [N_BINS];
   logic [WORD_SIZE-1:0] frame_im [N_BINS];
   logic                 scan_mode;
   logic [SEL_W-1:0]     scan_last;

   logic                 capture;
   logic                 handshake;
   logic                 last_beat;
   logic [SEL_W-1:0]     next_index;
   logic [WORD_SIZE-1:0] load_re;
   logic [WORD_SIZE-1:0] load_im;

   assign capture    = (state == IDLE) && i_frame_valid;
   assign handshake  = o_valid && i_ready;
   assign last_beat  = !scan_mode || (o_index == scan_last);
   assign next_index = o_index + SEL_W'(1);
   assign o_busy     = (state == EMIT);

   // On capture the buffer is being written on the same edge, so the first
   // word comes straight from the input bus; afterwards from the buffer.
   always_comb begin
      load_re = frame_re[next_index];
      load_im = frame_im[next_index];
      if (state == IDLE) begin
         load_re = i_bins_re[i_select*WORD_SIZE +: WORD_SIZE];
         load_im = i_bins_im[i_select*WORD_SIZE +: WORD_SIZE];
      end
   end

   always_ff @(posedge i_clk) begin
      if (capture) begin
         for (int k = 0; k < N_BINS; k++) begin
            frame_re[k] <= i_bins_re[k*WORD_SIZE +: WORD_SIZE];
            frame_im[k] <= i_bins_im[k*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

`ifdef HARMONIC_SELECT_MAGNITUDE_EN
   function automatic logic [WORD_SIZE:0] abs_ext(input logic [WORD_SIZE-1:0] v);
      logic [WORD_SIZE:0] x;
      x = {v[WORD_SIZE-1], v};
      return v[WORD_SIZE-1] ? -x : x;
   endfunction

   logic [WORD_SIZE:0] load_mag;
   assign load_mag = abs_ext(load_re) + abs_ext(load_im);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_magnitude <= '0;
      end else if (capture || (state == EMIT && handshake && !last_beat)) begin
         o_magnitude <= load_mag;
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         o_valid       <= 1'b0;
         o_harmonic_re <= '0;
         o_harmonic_im <= '0;
         o_index       <= '0;
         scan_mode     <= 1'b0;
         scan_last     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_frame_valid) begin
                  state         <= EMIT;
                  o_valid       <= 1'b1;
                  scan_mode     <= i_mode;
                  scan_last     <= i_scan_last;
                  o_index       <= i_select;
                  o_harmonic_re <= load_re;
                  o_harmonic_im <= load_im;
               end
            end
            EMIT: begin
               if (handshake) begin
                  if (last_beat) begin
                     state   <= IDLE;
                     o_valid <= 1'b0;
                  end else begin
                     o_index       <= next_index;
                     o_harmonic_re <= load_re;
                     o_harmonic_im <= load_im;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_harmonic_select.sv
// Directed bench for harmonic_select: table of capture/scan vectors plus hand-written corner sequences.
module tb_harmonic_select;
   localparam int W  = 16;
   localparam int N  = 16;
   localparam int SW = 4;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_frame_valid;
   logic [N*W-1:0]    i_bins_re;
   logic [N*W-1:0]    i_bins_im;
   logic              i_mode;
   logic [SW-1:0]     i_select;
   logic [SW-1:0]     i_scan_last;
   logic              i_ready;
   logic              o_valid;
   logic              o_busy;
   logic [W-1:0]      o_harmonic_re;
   logic [W-1:0]      o_harmonic_im;
   logic [SW-1:0]     o_index;
`ifdef HARMONIC_SELECT_MAGNITUDE_EN
   logic [W:0]        o_magnitude;
`endif

   harmonic_select #(.WORD_SIZE(W), .N_BINS(N)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_frame_valid(i_frame_valid),
      .i_bins_re(i_bins_re), .i_bins_im(i_bins_im), .i_mode(i_mode),
      .i_select(i_select), .i_scan_last(i_scan_last), .i_ready(i_ready),
      .o_valid(o_valid), .o_busy(o_busy), .o_harmonic_re(o_harmonic_re),
      .o_harmonic_im(o_harmonic_im), .o_index(o_index)
`ifdef HARMONIC_SELECT_MAGNITUDE_EN
      , .o_magnitude(o_magnitude)
`endif
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic       mode;
      logic [3:0] first;
      logic [3:0] last;
      int         count;
   } vec_t;

   vec_t        vecs [7];
   logic [W-1:0] m_re [N];
   logic [W-1:0] m_im [N];
   int          nvec  = 0;
   int          nfail = 0;

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

`ifdef HARMONIC_SELECT_MAGNITUDE_EN
   function automatic int exp_mag(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      int ra;
      int rb;
      ra = a;
      rb = b;
      if (ra < 0) ra = -ra;
      if (rb < 0) rb = -rb;
      return ra + rb;
   endfunction
`endif

   task automatic load_frame(input int base);
      for (int k = 0; k < N; k++) begin
         i_bins_re[k*W +: W] = W'(base + k);
         i_bins_im[k*W +: W] = W'(-(base + k));
      end
   endtask

   task automatic capture(input logic mode, input int first, input int last);
      i_mode        = mode;
      i_select      = SW'(first);
      i_scan_last   = SW'(last);
      i_frame_valid = 1'b1;
      for (int k = 0; k < N; k++) begin
         m_re[k] = i_bins_re[k*W +: W];
         m_im[k] = i_bins_im[k*W +: W];
      end
      tick();
      i_frame_valid = 1'b0;
   endtask

   task automatic check_bin(input string tag, input int idx);
      check({tag, " valid"}, o_valid, 1);
      check({tag, " busy"},  o_busy, 1);
      check({tag, " index"}, o_index, idx);
      check({tag, " re"},    o_harmonic_re, m_re[idx]);
      check({tag, " im"},    o_harmonic_im, m_im[idx]);
`ifdef HARMONIC_SELECT_MAGNITUDE_EN
      check({tag, " mag"},   o_magnitude, exp_mag(m_re[idx], m_im[idx]));
`endif
   endtask

   task automatic check_idle(input string tag);
      check({tag, " idle valid"}, o_valid, 0);
      check({tag, " idle busy"},  o_busy, 0);
   endtask

   initial begin
      // mode, first, last, expected bin count
      vecs[0] = '{1'b0, 4'd5,  4'd0,  1};
      vecs[1] = '{1'b1, 4'd14, 4'd1,  4};
      vecs[2] = '{1'b1, 4'd3,  4'd3,  1};
      vecs[3] = '{1'b1, 4'd0,  4'd15, 16};
      vecs[4] = '{1'b1, 4'd15, 4'd0,  2};
      vecs[5] = '{1'b1, 4'd2,  4'd6,  5};
      vecs[6] = '{1'b0, 4'd12, 4'd3,  1};

      i_rst = 1'b1; i_frame_valid = 1'b0; i_mode = 1'b0; i_select = '0;
      i_scan_last = '0; i_ready = 1'b1; i_bins_re = '0; i_bins_im = '0;
      #12;
      check("reset valid", o_valid, 0);
      check("reset busy",  o_busy, 0);
      check("reset index", o_index, 0);
      check("reset re",    o_harmonic_re, 0);
      check("reset im",    o_harmonic_im, 0);
`ifdef HARMONIC_SELECT_MAGNITUDE_EN
      check("reset mag",   o_magnitude, 0);
`endif
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // first vector is captured on the first edge after reset release
      for (int v = 0; v < 7; v++) begin
         load_frame(v * 256);
         capture(vecs[v].mode, int'(vecs[v].first), int'(vecs[v].last));
         for (int j = 0; j < vecs[v].count; j++) begin
            check_bin($sformatf("vec%0d beat%0d", v, j), (int'(vecs[v].first) + j) % N);
            tick();
         end
         check_idle($sformatf("vec%0d", v));
      end

      // backpressure: scan 2..4, ready low three cycles at index 3
      load_frame(40);
      capture(1'b1, 2, 4);
      check_bin("hold b2", 2);
      tick();
      i_ready = 1'b0;
      check_bin("hold b3 first", 3);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_bin($sformatf("hold b3 stall%0d", c), 3);
      end
      i_ready = 1'b1;
      tick();
      check_bin("hold b4", 4);
      tick();
      check_idle("hold");

      // new frame offered during EMIT, including at the final handshake
      load_frame(1000);
      capture(1'b1, 0, 3);
      check_bin("ign b0", 0);
      tick();
      check_bin("ign b1", 1);
      load_frame(3000);
      i_frame_valid = 1'b1; i_mode = 1'b0; i_select = 4'd9;
      tick();
      check_bin("ign b2", 2);
      tick();
      check_bin("ign b3", 3);
      tick();
      check_idle("ign end");
      i_frame_valid = 1'b0;
      tick();
      check_idle("ign after");

      // asynchronous reset mid-scan at index 7
      load_frame(500);
      capture(1'b1, 0, 15);
      for (int j = 0; j < 7; j++) begin
         tick();
      end
      check_bin("rst b7", 7);
      #2;
      i_rst = 1'b1;
      #1;
      check("rst async valid", o_valid, 0);
      check("rst async busy",  o_busy, 0);
      check("rst async index", o_index, 0);
      check("rst async re",    o_harmonic_re, 0);
      check("rst async im",    o_harmonic_im, 0);
      tick();
      check("rst held valid", o_valid, 0);
      i_rst = 1'b0;
      load_frame(700);
      capture(1'b0, 3, 0);
      check_bin("rst newframe", 3);
      tick();
      check_idle("rst newframe");

`ifdef HARMONIC_SELECT_MAGNITUDE_EN
      i_bins_re = '0;
      i_bins_im = '0;
      i_bins_re[0 +: W] = 16'h8000;
      i_bins_im[0 +: W] = 16'h7FFF;
      capture(1'b0, 0, 0);
      check("mag extreme", o_magnitude, 65535);
      check_bin("mag bin", 0);
      tick();
      check_idle("mag");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
